// File: rtl/axi_sram_slave.sv
// AXI-style SRAM slave: single outstanding INCR burst, read wins ties.
// Ports: clk/rst, AR+R read channel, AW+W+B write channel, 32-bit data.
module axi_sram_slave #(
  parameter int    ADDR_W    = 12,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  typedef enum logic [1:0] {
    IDLE, RD, WR, WRESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] ar_word;
  logic [ADDR_W-1:0] aw_word;
  logic [7:0]        cnt;
  logic              err;
  logic              ar_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              r_hs;
  logic              unused_bits;

  assign ar_word = araddr[ADDR_W+1:2];
  assign aw_word = awaddr[ADDR_W+1:2];
  assign addr_nx = addr + 1'b1;

  assign unused_bits = ^{araddr[31:ADDR_W+2], araddr[1:0],
                         awaddr[31:ADDR_W+2], awaddr[1:0]};

  assign arready = (state == IDLE) && !rst;
  assign awready = arready && !arvalid;
  assign rresp   = 2'b00;

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign r_hs  = rvalid && rready;

  // No reset: memory contents survive rst; wready drops
  // asynchronously so an aborted burst stops writing at once.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      rlast  <= 1'b0;
      rvalid <= 1'b0;
      wready <= 1'b0;
      bid    <= '0;
      bresp  <= 2'b00;
      bvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            state  <= RD;
            rid    <= arid;
            addr   <= ar_word;
            cnt    <= arlen;
            rdata  <= mem[ar_word];
            rlast  <= (arlen == 8'd0);
            rvalid <= 1'b1;
          end else if (aw_hs) begin
            state  <= WR;
            bid    <= awid;
            addr   <= aw_word;
            cnt    <= {4'b0000, awlen};
            err    <= 1'b0;
            wready <= 1'b1;
          end
        end
        RD: begin
          if (r_hs) begin
            if (cnt == 8'd0) begin
              state  <= IDLE;
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              addr  <= addr_nx;
              cnt   <= cnt - 8'd1;
              rdata <= mem[addr_nx];
              rlast <= (cnt == 8'd1);
            end
          end
        end
        WR: begin
          if (w_hs) begin
            addr <= addr_nx;
            if (cnt == 8'd0) begin
              // wlast must land exactly on the counted final beat
              state  <= WRESP;
              wready <= 1'b0;
              bvalid <= 1'b1;
              bresp  <= (err || !wlast) ? 2'b10 : 2'b00;
            end else begin
              cnt <= cnt - 8'd1;
              if (wlast) err <= 1'b1;
            end
          end
        end
        WRESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave.
// Drives bursts #1 after rising edges and checks with assertions.
module tb_axi_sram_slave;

  logic        clk;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int total = 0;
  int bad = 0;

  logic [31:0] wd   [16];
  logic [31:0] rexp [16];

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id,
                    input logic [31:0] a,
                    input logic [3:0] len,
                    input logic [3:0] strb,
                    input int lastbeat,
                    input logic [1:0] eresp);
    int n;
    awid = id; awaddr = a; awlen = len; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    chk("aw_wait", 32'(n < 50), 32'd1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd[i]; wstrb = strb;
      wlast = (i == lastbeat); wvalid = 1'b1;
      chk("wready", 32'(wready), 32'd1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(eresp));
    chk("bid", 32'(bid), 32'(id));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic rd(input logic [3:0] id,
                    input logic [31:0] a,
                    input logic [7:0] len,
                    input bit stall);
    int n;
    int beat;
    int cyc;
    arid = id; araddr = a; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    chk("ar_wait", 32'(n < 50), 32'd1);
    tick();
    arvalid = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 600) begin
      rready = stall ? (cyc % 2 == 0) : 1'b1;
      chk("rvalid", 32'(rvalid), 32'd1);
      chk("rdata", rdata, rexp[beat]);
      chk("rlast", 32'(rlast), 32'(beat == int'(len)));
      chk("rid", 32'(rid), 32'(id));
      chk("rresp", 32'(rresp), 32'd0);
      if (rready) beat++;
      tick();
      cyc++;
    end
    rready = 1'b0;
    chk("rd_done", 32'(cyc < 600), 32'd1);
    chk("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
    rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_bid", 32'(bid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_arready", 32'(arready), 32'd1);

    // single full-word write then read back
    wd[0] = 32'hDEADBEEF;
    wr(4'd3, 32'h100, 4'd0, 4'hF, 0, 2'b00);
    rexp[0] = 32'hDEADBEEF;
    rd(4'd5, 32'h100, 8'd0, 1'b0);

    // byte-lane 1 only
    wd[0] = 32'h0000AA00;
    wr(4'd4, 32'h100, 4'd0, 4'b0010, 0, 2'b00);
    rexp[0] = 32'hDEADAAEF;
    rd(4'd6, 32'h100, 8'd0, 1'b0);

    // 4-beat write, 4-beat read with rready 1,0,1,0...
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
    wr(4'd7, 32'h200, 4'd3, 4'hF, 3, 2'b00);
    rexp[0] = 32'd1; rexp[1] = 32'd2;
    rexp[2] = 32'd3; rexp[3] = 32'd4;
    rd(4'd8, 32'h200, 8'd3, 1'b1);

    // simultaneous AR and AW: read first
    arid = 4'd1; araddr = 32'h200; arlen = 8'd1; arvalid = 1'b1;
    awid = 4'd9; awaddr = 32'h300; awlen = 4'd0; awvalid = 1'b1;
    #1;
    chk("tie_arready", 32'(arready), 32'd1);
    chk("tie_awready", 32'(awready), 32'd0);
    tick();
    arvalid = 1'b0; rready = 1'b1;
    chk("tie_rd_awready", 32'(awready), 32'd0);
    chk("tie_b0", rdata, 32'd1);
    tick();
    chk("tie_b1", rdata, 32'd2);
    chk("tie_b1_last", 32'(rlast), 32'd1);
    chk("tie_b1_awready", 32'(awready), 32'd0);
    tick();
    rready = 1'b0;
    chk("tie_after_awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("tie_wready", 32'(wready), 32'd1);
    wdata = 32'h55; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    chk("tie_bvalid", 32'(bvalid), 32'd1);
    chk("tie_bresp", 32'(bresp), 32'd0);
    chk("tie_bid", 32'(bid), 32'd9);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    rexp[0] = 32'h55;
    rd(4'd2, 32'h300, 8'd0, 1'b0);

    // early wlast, burst wraps from top word to word 0
    wd[0] = 32'hA1A1A1A1; wd[1] = 32'hB2B2B2B2;
    wr(4'd10, 32'h3FFC, 4'd1, 4'hF, 0, 2'b10);
    rexp[0] = 32'hA1A1A1A1; rexp[1] = 32'hB2B2B2B2;
    rd(4'd11, 32'h3FFC, 8'd1, 1'b0);

    // reset during beat 2 of a 4-beat read
    arid = 4'd12; araddr = 32'h200; arlen = 8'd3; arvalid = 1'b1;
    tick();
    arvalid = 1'b0; rready = 1'b1;
    chk("ab_b0", rdata, 32'd1);
    tick();
    chk("ab_b1", rdata, 32'd2);
    rst = 1'b1;
    #1;
    chk("ab_rvalid", 32'(rvalid), 32'd0);
    chk("ab_arready", 32'(arready), 32'd0);
    rready = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("ab_rel_arready", 32'(arready), 32'd1);
    rexp[0] = 32'hDEADAAEF;
    rd(4'd13, 32'h100, 8'd0, 1'b0);
    rexp[0] = 32'd3; rexp[1] = 32'd4;
    rd(4'd14, 32'h208, 8'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
